// File: rtl/semi_auto_ctrl.sv
// rtl/semi_auto_ctrl.sv - semi-automatic drive controller (MOVE/WAIT/TURN/COOL sequencer)
//
// Sequences a vehicle through MOVE, WAIT, TURN and COOL on a 20 ms tick.
// In MOVE the obstacle detector picks automatic turns or stops; in WAIT a
// single user command starts a turn or a straight run. TURN and COOL are
// timed phases that ignore the detector and commands.
//
// Ports:
//   clk_20ms      in   20 ms tick clock, rising edge
//   rst           in   asynchronous active-low reset
//   power         in   1 = vehicle powered
//   global_state  in   [1:0] block enabled for 2'b01 or 2'b10
//   detector      in   [3:0] blocked flags: [3] front [2] back [1] left [0] right
//   cmd_left/cmd_right/cmd_straight/cmd_back  in  user commands (one-hot to count)
//   state         out  [1:0] MOVE=00 WAIT=01 TURN=10 COOL=11
//   moving_state  out  [3:0] MOVE 1000, WAIT 0000, TURN 0100, COOL 0001
//   turn_dir      out  [1:0] 10 left, 01 right, 00 none
//   uturn         out  1 while the current/last turn is a U-turn
//   turn_count    out  [CNT_W-1:0] completed turns, saturating
module semi_auto_ctrl #(
  parameter int TURN_TICKS  = 50,
  parameter int UTURN_TICKS = 100,
  parameter int COOL_TICKS  = 50,
  parameter int GRACE_TICKS = 25,
  parameter int CNT_W       = 8
) (
  input  logic             clk_20ms,
  input  logic             rst,
  input  logic             power,
  input  logic [1:0]       global_state,
  input  logic [3:0]       detector,
  input  logic             cmd_left,
  input  logic             cmd_right,
  input  logic             cmd_straight,
  input  logic             cmd_back,
  output logic [1:0]       state,
  output logic [3:0]       moving_state,
  output logic [1:0]       turn_dir,
  output logic             uturn,
  output logic [CNT_W-1:0] turn_count
);

  typedef enum logic [1:0] {
    S_MOVE = 2'b00,
    S_WAIT = 2'b01,
    S_TURN = 2'b10,
    S_COOL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(UTURN_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_TICKS);

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] grace;
  logic [1:0]       dir_n;
  logic             uturn_n;
  logic [3:0]       ms_n;
  logic             enable;
  logic             one_cmd;
  logic             grace_expired;
  logic             count_turn;
  logic             load_grace;
  logic [3:0]       cmds;

  assign state = state_q;
  assign cmds  = {cmd_left, cmd_right, cmd_straight, cmd_back};

  always_ff @(posedge clk_20ms or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT;
      moving_state <= 4'b0000;
      turn_dir     <= DIR_NONE;
      uturn        <= 1'b0;
      turn_count   <= '0;
      tick         <= '0;
      grace        <= '0;
    end else begin
      state_q      <= state_n;
      moving_state <= ms_n;
      turn_dir     <= dir_n;
      uturn        <= uturn_n;

      if (!enable || (state_n != state_q)) begin
        tick <= '0;
      end else begin
        tick <= tick + ONE;
      end

      // Grace only lives while MOVE persists after a COOL exit; any other
      // way of being in or leaving MOVE leaves it expired (zero).
      if (!enable) begin
        grace <= '0;
      end else if (load_grace) begin
        grace <= GRACE_LOAD;
      end else if (state_n != S_MOVE) begin
        grace <= '0;
      end else if (grace != '0) begin
        grace <= grace - ONE;
      end

      if (count_turn && (turn_count != '1)) begin
        turn_count <= turn_count + ONE;
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    dir_n      = turn_dir;
    uturn_n    = uturn;
    count_turn = 1'b0;
    load_grace = 1'b0;
    ms_n       = 4'b0000;

    enable  = power & ((global_state == 2'b01) | (global_state == 2'b10));
    one_cmd = $onehot(cmds);
    // The loaded value counts down once per MOVE cycle; stops unlock on the
    // last suppressed cycle so MOVE is held for exactly GRACE_TICKS cycles.
    grace_expired = (grace <= ONE);

    if (!enable) begin
      state_n = S_WAIT;
      dir_n   = DIR_NONE;
      uturn_n = 1'b0;
    end else begin
      case (state_q)
        S_MOVE: begin
          if (detector == 4'b1011) begin
            state_n = S_TURN;
            dir_n   = DIR_RIGHT;
            uturn_n = 1'b1;
          end else if (detector == 4'b1001) begin
            state_n = S_TURN;
            dir_n   = DIR_LEFT;
            uturn_n = 1'b0;
          end else if (detector == 4'b1010) begin
            state_n = S_TURN;
            dir_n   = DIR_RIGHT;
            uturn_n = 1'b0;
          end else if (detector[3]) begin
            state_n = S_WAIT;
          end else if ((!detector[1] || !detector[0]) && grace_expired) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (one_cmd) begin
            if (cmd_left && !detector[1]) begin
              state_n = S_TURN;
              dir_n   = DIR_LEFT;
              uturn_n = 1'b0;
            end else if (cmd_right && !detector[0]) begin
              state_n = S_TURN;
              dir_n   = DIR_RIGHT;
              uturn_n = 1'b0;
            end else if (cmd_straight && !detector[3]) begin
              state_n = S_COOL;
              dir_n   = DIR_NONE;
              uturn_n = 1'b0;
            end else if (cmd_back) begin
              state_n = S_TURN;
              dir_n   = DIR_RIGHT;
              uturn_n = 1'b1;
            end
          end
        end
        S_TURN: begin
          if (tick == (uturn ? UTURN_LAST : TURN_LAST)) begin
            state_n    = S_COOL;
            count_turn = 1'b1;
          end
        end
        S_COOL: begin
          if (tick == COOL_LAST) begin
            state_n    = S_MOVE;
            dir_n      = DIR_NONE;
            uturn_n    = 1'b0;
            load_grace = 1'b1;
          end
        end
        default: state_n = S_WAIT;
      endcase
    end

    case (state_n)
      S_MOVE:  ms_n = 4'b1000;
      S_TURN:  ms_n = 4'b0100;
      S_COOL:  ms_n = 4'b0001;
      default: ms_n = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_semi_auto_ctrl.sv
// tb/tb_semi_auto_ctrl.sv - scoreboard bench for semi_auto_ctrl
module tb_semi_auto_ctrl;

  localparam int T_TURN  = 50;
  localparam int T_UTURN = 100;
  localparam int T_COOL  = 50;
  localparam int T_GRACE = 25;

  localparam logic [3:0] C_L = 4'b1000;
  localparam logic [3:0] C_R = 4'b0100;
  localparam logic [3:0] C_S = 4'b0010;
  localparam logic [3:0] C_B = 4'b0001;
  localparam logic [3:0] C_0 = 4'b0000;

  localparam int M_MOVE = 0;
  localparam int M_WAIT = 1;
  localparam int M_TURN = 2;
  localparam int M_COOL = 3;

  logic       clk_20ms = 1'b0;
  logic       rst;
  logic       power;
  logic [1:0] global_state;
  logic [3:0] detector;
  logic       cmd_left, cmd_right, cmd_straight, cmd_back;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic [1:0] turn_dir;
  logic       uturn;
  logic [7:0] turn_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  logic [16:0] exp_q[$];

  // reference model: phase, cycles left in timed phase, MOVE cycles since COOL exit
  int m_mode, m_left, m_mc, m_dir, m_u, m_cnt;

  semi_auto_ctrl dut (
    .clk_20ms     (clk_20ms),
    .rst          (rst),
    .power        (power),
    .global_state (global_state),
    .detector     (detector),
    .cmd_left     (cmd_left),
    .cmd_right    (cmd_right),
    .cmd_straight (cmd_straight),
    .cmd_back     (cmd_back),
    .state        (state),
    .moving_state (moving_state),
    .turn_dir     (turn_dir),
    .uturn        (uturn),
    .turn_count   (turn_count)
  );

  always #10 clk_20ms = ~clk_20ms;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got st=%b ms=%b dir=%b u=%b cnt=%0d, want st=%b ms=%b dir=%b u=%b cnt=%0d",
               name, got[16:15], got[14:11], got[10:9], got[8], got[7:0],
               want[16:15], want[14:11], want[10:9], want[8], want[7:0]);
    end
  endtask

  function automatic logic [16:0] model_vec();
    logic [3:0] ms;
    case (m_mode)
      M_MOVE:  ms = 4'b1000;
      M_TURN:  ms = 4'b0100;
      M_COOL:  ms = 4'b0001;
      default: ms = 4'b0000;
    endcase
    return {2'(m_mode), ms, 2'(m_dir), 1'(m_u), 8'(m_cnt)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {state, moving_state, turn_dir, uturn, turn_count};
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT; m_left = 0; m_mc = 0; m_dir = 0; m_u = 0; m_cnt = 0;
  endtask

  task automatic start_turn(input int dir, input int u);
    m_mode = M_TURN; m_dir = dir; m_u = u;
    m_left = u ? T_UTURN : T_TURN;
  endtask

  task automatic model_step(input logic p, input logic [1:0] gs, input logic [3:0] det, input logic [3:0] cmd);
    bit en;
    en = p && (gs == 2'b01 || gs == 2'b10);
    if (!en) begin
      m_mode = M_WAIT; m_dir = 0; m_u = 0; m_left = 0; m_mc = 0;
      return;
    end
    case (m_mode)
      M_MOVE: begin
        m_mc++;
        if (det == 4'b1011)      start_turn(1, 1);
        else if (det == 4'b1001) start_turn(2, 0);
        else if (det == 4'b1010) start_turn(1, 0);
        else if (det[3])         m_mode = M_WAIT;
        else if ((!det[1] || !det[0]) && m_mc >= T_GRACE) m_mode = M_WAIT;
      end
      M_WAIT: begin
        if ($countones(cmd) == 1) begin
          if (cmd[3] && !det[1])      start_turn(2, 0);
          else if (cmd[2] && !det[0]) start_turn(1, 0);
          else if (cmd[1] && !det[3]) begin
            m_mode = M_COOL; m_left = T_COOL; m_dir = 0; m_u = 0;
          end
          else if (cmd[0])            start_turn(1, 1);
        end
      end
      M_TURN: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_COOL; m_left = T_COOL;
          if (m_cnt < 255) m_cnt++;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_MOVE; m_dir = 0; m_u = 0; m_mc = 0;
        end
      end
    endcase
  endtask

  // Called at a falling edge; drives inputs, predicts the next edge, waits one cycle.
  task automatic step(input logic p, input logic [1:0] gs, input logic [3:0] det, input logic [3:0] cmd);
    power = p; global_state = gs; detector = det;
    {cmd_left, cmd_right, cmd_straight, cmd_back} = cmd;
    model_step(p, gs, det, cmd);
    exp_q.push_back(model_vec());
    @(negedge clk_20ms);
  endtask

  task automatic idle(input int n, input logic [3:0] det);
    for (int i = 0; i < n; i++) step(1'b1, 2'b01, det, C_0);
  endtask

  initial begin : monitor
    logic [16:0] want;
    forever begin
      @(posedge clk_20ms);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_cycle++;
        check($sformatf("cycle%0d", n_cycle), dut_vec(), want);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] det;
    logic [3:0] cmd;
    logic [1:0] gs;
    logic       p;
    int         r;

    rst = 1'b1; power = 1'b0; global_state = 2'b00; detector = 4'b0000;
    {cmd_left, cmd_right, cmd_straight, cmd_back} = 4'b0000;
    #1 rst = 1'b0;
    #3;
    model_reset();
    check("reset_initial", dut_vec(), model_vec());
    @(negedge clk_20ms);
    rst = 1'b1;

    // left turn from WAIT, through COOL into MOVE, then junction stop after grace
    step(1'b1, 2'b01, 4'b0000, C_L);
    idle(130, 4'b0000);

    // left blocked: left ignored, right accepted
    step(1'b1, 2'b01, 4'b0010, C_L);
    step(1'b1, 2'b01, 4'b0010, C_R);
    idle(100, 4'b0011);
    // U-turn from MOVE
    step(1'b1, 2'b10, 4'b1011, C_0);
    idle(160, 4'b0011);
    step(1'b1, 2'b01, 4'b1000, C_0);

    // straight into COOL, then left turn at MOVE cycle 5 despite grace
    step(1'b1, 2'b01, 4'b0000, C_S);
    idle(50, 4'b0000);
    idle(4, 4'b0000);
    step(1'b1, 2'b01, 4'b1001, C_0);
    idle(120, 4'b0011);
    step(1'b1, 2'b01, 4'b1000, C_0);

    // power drop mid-TURN, then conflicting commands in WAIT
    step(1'b1, 2'b01, 4'b0000, C_L);
    idle(19, 4'b0000);
    step(1'b0, 2'b01, 4'b0000, C_0);
    step(1'b1, 2'b01, 4'b0000, C_L | C_R);
    step(1'b1, 2'b01, 4'b0000, C_S | C_B);
    step(1'b1, 2'b01, 4'b0000, C_B);
    idle(160, 4'b0011);
    step(1'b1, 2'b01, 4'b1000, C_0);

    // saturate turn_count
    for (int t = 0; t < 256; t++) begin
      step(1'b1, 2'b01, 4'b0000, C_L);
      idle(100, 4'b0000);
      step(1'b1, 2'b01, 4'b1000, C_0);
    end

    // asynchronous reset mid-COOL, between clock edges
    step(1'b1, 2'b01, 4'b0000, C_L);
    idle(70, 4'b0000);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("reset_mid_cool", dut_vec(), model_vec());
    @(negedge clk_20ms);
    @(negedge clk_20ms);
    check("reset_held", dut_vec(), model_vec());
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      p  = ($urandom_range(0, 99) < 98);
      gs = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3))
                                       : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        case ($urandom_range(0, 4))
          0: det = 4'b0011;
          1: det = 4'b0111;
          2: det = 4'b1011;
          3: det = 4'b1001;
          default: det = 4'b1010;
        endcase
      end else begin
        det = 4'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 9);
      if (r < 5)      cmd = 4'b0001 << $urandom_range(0, 3);
      else if (r < 8) cmd = C_0;
      else            cmd = 4'($urandom_range(0, 15));
      step(p, gs, det, cmd);
    end

    @(posedge clk_20ms);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
